// File: rtl/if_fetch_stage.sv
// if_fetch_stage
//   Instruction-fetch stage feeding the IF/ID pipeline register. Owns the PC,
//   issues one outstanding request at a time to instruction memory using a
//   request/grant/response handshake, buffers a single fetched instruction and
//   presents it with its PC+4. Handles freeze (hazard stall) and branch/jump
//   redirects, and mirrors branch_taken onto flush_out toward IF/ID.
//
//   Optional feature: define IF_FETCH_PERF_CNT_EN to add the perf_stall_cycles
//   and perf_redirects counter outputs.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   freeze             hazard stall; buffered instruction not consumed
//   branch_taken       redirect pulse from a later stage
//   branch_target      redirect PC; low two bits are forced to zero
//   imem_req/addr      fetch request and word-aligned fetch address
//   imem_gnt           memory accepts the request this cycle
//   imem_rvalid/rdata  response valid and instruction word
//   PCplus4Out         PC+4 of the buffered instruction
//   instructionOut     buffered instruction, 0 (NOP) when not valid
//   valid_out          buffer holds a valid instruction
//   flush_out          combinational copy of branch_taken
//   perf_stall_cycles  (optional) cycles with no valid instruction buffered
//   perf_redirects     (optional) cycles with branch_taken asserted
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int unsigned XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            freeze,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] PCplus4Out,
  output logic [XLEN-1:0] instructionOut,
  output logic            valid_out,
`ifdef IF_FETCH_PERF_CNT_EN
  output logic [XLEN-1:0] perf_stall_cycles,
  output logic [XLEN-1:0] perf_redirects,
`endif
  output logic            flush_out
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_FULL    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redirect_pc;
  logic            consume;

  // Buffered instruction leaves toward IF/ID this cycle.
  assign consume     = valid_out & ~freeze & ~branch_taken;
  assign pc_plus4    = pc + XLEN'(4);
  assign redirect_pc = branch_target & ~XLEN'(3);

  // Next fetch can be issued in the same cycle the buffer drains.
  assign imem_req  = (state == S_REQ) | ((state == S_FULL) & consume);
  assign imem_addr = pc;
  assign flush_out = branch_taken;

  // Fetch FSM, PC and instruction buffer. Redirect outranks freeze and capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_REQ;
      pc             <= RESET_PC;
      valid_out      <= 1'b0;
      instructionOut <= '0;
      PCplus4Out     <= '0;
    end else if (branch_taken) begin
      pc             <= redirect_pc;
      valid_out      <= 1'b0;
      instructionOut <= '0;
      PCplus4Out     <= '0;
      // A request granted or still in flight must have its response dropped.
      case (state)
        S_REQ:     state <= imem_gnt    ? S_DISCARD : S_REQ;
        S_WAIT:    state <= imem_rvalid ? S_REQ     : S_DISCARD;
        S_FULL:    state <= S_REQ;
        S_DISCARD: state <= imem_rvalid ? S_REQ     : S_DISCARD;
        default:   state <= S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (imem_gnt) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            instructionOut <= imem_rdata;
            PCplus4Out     <= pc_plus4;
            pc             <= pc_plus4;
            valid_out      <= 1'b1;
            state          <= S_FULL;
          end
        end
        S_FULL: begin
          // Under freeze everything holds; otherwise drain and refetch.
          if (consume) begin
            valid_out      <= 1'b0;
            instructionOut <= '0;
            state          <= imem_gnt ? S_WAIT : S_REQ;
          end
        end
        S_DISCARD: begin
          if (imem_rvalid) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

`ifdef IF_FETCH_PERF_CNT_EN
  // Free-running performance counters, wrapping at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_redirects    <= '0;
    end else begin
      if (!valid_out)   perf_stall_cycles <= perf_stall_cycles + XLEN'(1);
      if (branch_taken) perf_redirects    <= perf_redirects + XLEN'(1);
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage
//   Bench for if_fetch_stage: directed scenarios plus a randomized run checked
//   against a program-order model (delivered PCs follow +4 from the last
//   redirect target, data matches the memory image, freeze holds, consume
//   empties the buffer). Memory responds with a random 1..3 cycle latency.
module tb_if_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] PCplus4Out;
  logic [31:0] instructionOut;
  logic        valid_out;
  logic        flush_out;
`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_redirects;
`endif

  if_fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .PCplus4Out     (PCplus4Out),
    .instructionOut (instructionOut),
    .valid_out      (valid_out),
`ifdef IF_FETCH_PERF_CNT_EN
    .perf_stall_cycles (perf_stall_cycles),
    .perf_redirects    (perf_redirects),
`endif
    .flush_out      (flush_out)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Memory image: explicit entries override a hashed default.
  logic [31:0] mem [logic [31:0]];
  bit          outstanding = 1'b0;
  int          lat_cnt = 0;
  logic [31:0] out_addr = '0;
  bit          gnt_en = 1'b1;
  int          lat = 1;
  bit          stray_rv = 1'b0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // One clock of memory behaviour; inputs freeze/branch are set by the caller.
  task automatic step();
    bit          fire;
    bit          granted;
    logic [31:0] gaddr;
    fire = outstanding && (lat_cnt == 0);
    if (outstanding && lat_cnt > 0) lat_cnt--;
    imem_rvalid = fire || stray_rv;
    imem_rdata  = fire ? mem_rd(out_addr) : 32'($urandom());
    #1;
    imem_gnt = gnt_en && imem_req;
    granted  = imem_gnt;
    gaddr    = imem_addr;
    @(posedge clk);
    if (fire) outstanding = 1'b0;
    if (granted) begin
      outstanding = 1'b1;
      out_addr    = gaddr;
      lat_cnt     = lat - 1;
    end
    #1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    freeze        = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    imem_gnt      = 1'b0;
    imem_rvalid   = 1'b0;
    outstanding   = 1'b0;
    lat_cnt       = 0;
    stray_rv      = 1'b0;
    gnt_en        = 1'b1;
    lat           = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b want 0", valid_out); end
    checks++; if (instructionOut !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h want 0", instructionOut); end
    checks++; if (PCplus4Out !== 32'h0) begin failures++; $display("FAIL reset_pc4: got %h want 0", PCplus4Out); end
    checks++; if (imem_addr !== RESET_PC) begin failures++; $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC); end
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL reset_req: got %0b want 1", imem_req); end
  endtask

  task automatic test_stream();
    bit ev;
    do_reset();
    gnt_en = 1'b1;
    lat    = 1;
    for (int k = 0; k <= 6; k++) begin
      ev = (k >= 2) && (k % 2 == 0);
      checks++; if (valid_out !== ev) begin failures++; $display("FAIL stream_valid[%0d]: got %0b want %0b", k, valid_out, ev); end
      if (k % 2 == 0) begin
        checks++; if (imem_addr !== 32'(2 * k)) begin failures++; $display("FAIL stream_addr[%0d]: got %h want %h", k, imem_addr, 32'(2 * k)); end
        if (ev) begin
          checks++; if (PCplus4Out !== 32'(2 * k)) begin failures++; $display("FAIL stream_pc4[%0d]: got %h want %h", k, PCplus4Out, 32'(2 * k)); end
          checks++; if (instructionOut !== mem_rd(32'(2 * k - 4))) begin failures++; $display("FAIL stream_instr[%0d]: got %h want %h", k, instructionOut, mem_rd(32'(2 * k - 4))); end
        end
      end
      if (k < 6) step();
    end
  endtask

  task automatic test_freeze();
    mem[32'h0] = 32'h2008_0005;
    do_reset();
    step();
    step();
    checks++; if ({valid_out, instructionOut} !== {1'b1, 32'h2008_0005}) begin failures++; $display("FAIL freeze_load: got %0b/%h want 1/20080005", valid_out, instructionOut); end
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL freeze_req[%0d]: got %0b want 0", i, imem_req); end
      checks++; if (imem_addr !== 32'h4) begin failures++; $display("FAIL freeze_pc[%0d]: got %h want 4", i, imem_addr); end
      step();
      checks++; if ({valid_out, instructionOut, PCplus4Out} !== {1'b1, 32'h2008_0005, 32'h4}) begin failures++; $display("FAIL freeze_hold[%0d]: got %0b/%h/%h want 1/20080005/4", i, valid_out, instructionOut, PCplus4Out); end
    end
    freeze = 1'b0;
    #1;
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h4}) begin failures++; $display("FAIL unfreeze_req: got %0b/%h want 1/4", imem_req, imem_addr); end
    step();
    checks++; if ({valid_out, instructionOut} !== {1'b0, 32'h0}) begin failures++; $display("FAIL unfreeze_consume: got %0b/%h want 0/0", valid_out, instructionOut); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    lat = 3;
    step();
    branch_taken  = 1'b1;
    branch_target = 32'h103;
    #1;
    checks++; if (flush_out !== 1'b1) begin failures++; $display("FAIL rw_flush: got %0b want 1", flush_out); end
    step();
    branch_taken = 1'b0;
    #1;
    checks++; if (flush_out !== 1'b0) begin failures++; $display("FAIL rw_flush_drop: got %0b want 0", flush_out); end
    checks++; if ({valid_out, imem_req, imem_addr} !== {1'b0, 1'b0, 32'h100}) begin failures++; $display("FAIL rw_discard: got v=%0b req=%0b addr=%h want 0/0/100", valid_out, imem_req, imem_addr); end
    lat = 1;
    step();
    step();
    checks++; if ({valid_out, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h100}) begin failures++; $display("FAIL rw_dropped: got v=%0b req=%0b addr=%h want 0/1/100", valid_out, imem_req, imem_addr); end
    step();
    step();
    checks++; if ({valid_out, PCplus4Out, instructionOut} !== {1'b1, 32'h104, mem_rd(32'h100)}) begin failures++; $display("FAIL rw_refetch: got %0b/%h/%h want 1/104/%h", valid_out, PCplus4Out, instructionOut, mem_rd(32'h100)); end
  endtask

  task automatic test_redirect_rvalid();
    do_reset();
    lat = 1;
    step();
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    gnt_en        = 1'b0;
    step();
    branch_taken = 1'b0;
    #1;
    checks++; if ({valid_out, instructionOut, PCplus4Out} !== {1'b0, 32'h0, 32'h0}) begin failures++; $display("FAIL rr_drop: got %0b/%h/%h want 0/0/0", valid_out, instructionOut, PCplus4Out); end
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h40}) begin failures++; $display("FAIL rr_req: got %0b/%h want 1/40", imem_req, imem_addr); end
    step();
    checks++; if ({valid_out, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h40}) begin failures++; $display("FAIL rr_stay: got %0b/%0b/%h want 0/1/40", valid_out, imem_req, imem_addr); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    lat = 2;
    step();
    branch_taken  = 1'b1;
    branch_target = 32'h200;
    step();
    branch_target = 32'h300;
    step();
    branch_taken = 1'b0;
    gnt_en       = 1'b0;
    #1;
    checks++; if ({imem_req, imem_addr, valid_out} !== {1'b1, 32'h300, 1'b0}) begin failures++; $display("FAIL b2b_last: got %0b/%h/%0b want 1/300/0", imem_req, imem_addr, valid_out); end
    gnt_en = 1'b1;
    lat    = 1;
    step();
    step();
    checks++; if ({valid_out, PCplus4Out} !== {1'b1, 32'h304}) begin failures++; $display("FAIL b2b_fetch: got %0b/%h want 1/304", valid_out, PCplus4Out); end
  endtask

  task automatic test_wrap();
    do_reset();
    gnt_en        = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFF;
    step();
    branch_taken = 1'b0;
    #1;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_align: got %h want fffffffc", imem_addr); end
    gnt_en = 1'b1;
    lat    = 1;
    step();
    step();
    checks++; if ({valid_out, PCplus4Out, imem_addr} !== {1'b1, 32'h0, 32'h0}) begin failures++; $display("FAIL wrap_pc: got %0b/%h/%h want 1/0/0", valid_out, PCplus4Out, imem_addr); end
    checks++; if (instructionOut !== mem_rd(32'hFFFF_FFFC)) begin failures++; $display("FAIL wrap_instr: got %h want %h", instructionOut, mem_rd(32'hFFFF_FFFC)); end
  endtask

  task automatic test_async_reset();
    do_reset();
    lat = 1;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    checks++; if ({valid_out, instructionOut, PCplus4Out} !== {1'b0, 32'h0, 32'h0}) begin failures++; $display("FAIL areset_full: got %0b/%h/%h want 0/0/0", valid_out, instructionOut, PCplus4Out); end
    do_reset();
    lat = 1;
    step();
    step();
    lat = 3;
    step();
    #2 rst = 1'b1;
    #1;
    checks++; if ({imem_addr, imem_req, valid_out} !== {RESET_PC, 1'b1, 1'b0}) begin failures++; $display("FAIL areset_wait: got %h/%0b/%0b want %h/1/0", imem_addr, imem_req, valid_out, RESET_PC); end
    do_reset();
    gnt_en   = 1'b0;
    stray_rv = 1'b1;
    step();
    step();
    checks++; if ({valid_out, instructionOut, imem_req, imem_addr} !== {1'b0, 32'h0, 1'b1, RESET_PC}) begin failures++; $display("FAIL stray_rvalid: got %0b/%h/%0b/%h want 0/0/1/%h", valid_out, instructionOut, imem_req, imem_addr, RESET_PC); end
    stray_rv = 1'b0;
    gnt_en   = 1'b1;
    step();
    step();
    checks++; if ({valid_out, PCplus4Out} !== {1'b1, RESET_PC + 32'h4}) begin failures++; $display("FAIL stray_then_fetch: got %0b/%h want 1/%h", valid_out, PCplus4Out, RESET_PC + 32'h4); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] pi;
    logic [31:0] pp;
    bit          pv;
    bit          bt_now;
    bit          fz_now;
    int          deliveries = 0;
    do_reset();
    exp_pc = RESET_PC;
    for (int n = 0; n < 3000; n++) begin
      fz_now        = ($urandom_range(0, 99) < 30);
      bt_now        = ($urandom_range(0, 99) < 6);
      freeze        = fz_now;
      branch_taken  = bt_now;
      branch_target = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : 32'($urandom_range(0, 4095));
      gnt_en        = ($urandom_range(0, 99) < 60);
      lat           = $urandom_range(1, 3);
      pv = valid_out;
      pi = instructionOut;
      pp = PCplus4Out;
      #1;
      checks++; if (flush_out !== bt_now) begin failures++; $display("FAIL rnd_flush[%0d]: got %0b want %0b", n, flush_out, bt_now); end
      checks++; if (outstanding && imem_req) begin failures++; $display("FAIL rnd_single_outstanding[%0d]: got req=1 want 0", n); end
      step();
      if (bt_now) begin
        exp_pc = branch_target & ~32'd3;
        checks++; if ({valid_out, instructionOut, PCplus4Out} !== {1'b0, 32'h0, 32'h0}) begin failures++; $display("FAIL rnd_redirect_clear[%0d]: got %0b/%h/%h want 0/0/0", n, valid_out, instructionOut, PCplus4Out); end
      end else if (pv && fz_now) begin
        checks++; if ({valid_out, instructionOut, PCplus4Out} !== {1'b1, pi, pp}) begin failures++; $display("FAIL rnd_freeze_hold[%0d]: got %0b/%h/%h want 1/%h/%h", n, valid_out, instructionOut, PCplus4Out, pi, pp); end
      end else if (pv) begin
        checks++; if ({valid_out, instructionOut} !== {1'b0, 32'h0}) begin failures++; $display("FAIL rnd_consume[%0d]: got %0b/%h want 0/0", n, valid_out, instructionOut); end
      end else if (valid_out) begin
        checks++; if (PCplus4Out !== exp_pc + 32'd4) begin failures++; $display("FAIL rnd_pc_order[%0d]: got %h want %h", n, PCplus4Out, exp_pc + 32'd4); end
        checks++; if (instructionOut !== mem_rd(exp_pc)) begin failures++; $display("FAIL rnd_data[%0d]: got %h want %h", n, instructionOut, mem_rd(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
        deliveries++;
      end else begin
        checks++; if (instructionOut !== 32'h0) begin failures++; $display("FAIL rnd_nop[%0d]: got %h want 0", n, instructionOut); end
      end
    end
    freeze       = 1'b0;
    branch_taken = 1'b0;
    checks++; if (deliveries < 150) begin failures++; $display("FAIL rnd_progress: got %0d deliveries want >=150", deliveries); end
  endtask

`ifdef IF_FETCH_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    checks++; if ({perf_stall_cycles, perf_redirects} !== 64'h0) begin failures++; $display("FAIL perf_reset: got %h/%h want 0/0", perf_stall_cycles, perf_redirects); end
    gnt_en        = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h80;
    step();
    branch_target = 32'h90;
    step();
    branch_taken = 1'b0;
    repeat (3) step();
    checks++; if (perf_redirects !== 32'd2) begin failures++; $display("FAIL perf_redirects: got %0d want 2", perf_redirects); end
    checks++; if (perf_stall_cycles !== 32'd5) begin failures++; $display("FAIL perf_stalls: got %0d want 5", perf_stall_cycles); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_freeze();
    test_redirect_wait();
    test_redirect_rvalid();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    test_random();
`ifdef IF_FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
